// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared timing description for the VGA timing generator.
//   timing_t holds one video mode: horizontal and vertical active, front porch,
//   sync and back porch lengths (in pixels / lines), plus sync polarity
//   (1 = sync pulse is driven high, 0 = sync pulse is driven low).
package vga_timing_pkg;

    typedef struct packed {
        logic [15:0] h_active;
        logic [15:0] h_fp;
        logic [15:0] h_sync;
        logic [15:0] h_bp;
        logic [15:0] v_active;
        logic [15:0] v_fp;
        logic [15:0] v_sync;
        logic [15:0] v_bp;
        logic        h_pol;
        logic        v_pol;
    } timing_t;

    // 640x480 @ 60 Hz, 25.175 MHz pixel clock, negative syncs
    localparam timing_t TIMING_640X480_60 = '{
        h_active: 16'd640, h_fp: 16'd16, h_sync: 16'd96,  h_bp: 16'd48,
        v_active: 16'd480, v_fp: 16'd10, v_sync: 16'd2,   v_bp: 16'd33,
        h_pol: 1'b0, v_pol: 1'b0
    };

    // 800x600 @ 60 Hz, 40 MHz pixel clock, positive syncs
    localparam timing_t TIMING_800X600_60 = '{
        h_active: 16'd800, h_fp: 16'd40, h_sync: 16'd128, h_bp: 16'd88,
        v_active: 16'd600, v_fp: 16'd1,  v_sync: 16'd4,   v_bp: 16'd23,
        h_pol: 1'b1, v_pol: 1'b1
    };

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter
//   Wrapping counter used for one axis (horizontal or vertical) of the raster.
//   Ports:
//     i_clk    - clock, rising edge
//     i_rst    - synchronous active-high reset, clears the count
//     i_en     - advance by one this cycle
//     i_last   - terminal value; the count wraps to 0 after it
//     o_count  - current count
//     o_tc     - high while o_count equals i_last
module vga_axis_counter #(
    parameter int CW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_en,
    input  logic [CW-1:0] i_last,
    output logic [CW-1:0] o_count,
    output logic          o_tc
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign o_tc    = (count_q == i_last);
    assign o_count = count_q;

    always_comb begin
        count_d = count_q;
        if (i_en) begin
            count_d = o_tc ? '0 : count_q + CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator
//   Raster timing generator with two selectable modes. Horizontal and vertical
//   counters advance on the pixel strobe; every output is a combinational decode
//   of the registered counters and the registered mode, so outputs describe the
//   pixel at the current counter position with no extra latency.
//   The requested mode is taken only at the end-of-frame wrap so a frame is
//   never generated with mixed timing.
//   Ports:
//     i_clk, i_rst       - clock and synchronous active-high reset
//     i_pix_stb          - pixel strobe; nothing changes while it is low
//     i_mode_sel         - requested mode (0 = MODE0, 1 = MODE1)
//     o_mode             - mode currently generated
//     o_hs, o_vs         - sync pulses at the active mode's polarity
//     o_blanking         - high outside the active region
//     o_line_start       - h_count == 0
//     o_frame_start      - h_count == 0 and v_count == 0
//     o_animate          - last pixel of the last active line
//     o_x, o_y           - active pixel coordinates, clamped during blanking
//     o_frame_cnt        - frame counter, present only with
//                          VGA_TIMING_FRAME_COUNT_EN defined
module vga_timing_generator
    import vga_timing_pkg::*;
#(
    parameter timing_t MODE0 = TIMING_640X480_60,
    parameter timing_t MODE1 = TIMING_800X600_60,
    parameter int      CW    = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_pix_stb,
    input  logic          i_mode_sel,
    output logic          o_mode,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_blanking,
    output logic          o_line_start,
    output logic          o_frame_start,
    output logic          o_animate,
    output logic [CW-1:0] o_x,
    output logic [CW-1:0] o_y
`ifdef VGA_TIMING_FRAME_COUNT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);

    logic          mode_q;
    logic          mode_d;
    timing_t       tm;

    logic [CW-1:0] h_act, h_sync_s, h_sync_e, h_last;
    logic [CW-1:0] v_act, v_sync_s, v_sync_e, v_last;
    logic [CW-1:0] h_count, v_count;
    logic          h_tc, v_tc;
    logic          frame_wrap;
    logic          hs_on, vs_on;

    assign tm = mode_q ? MODE1 : MODE0;

    // Region boundaries, all in CW bits: sync spans [act+fp, act+fp+sync).
    assign h_act    = CW'(tm.h_active);
    assign h_sync_s = h_act + CW'(tm.h_fp);
    assign h_sync_e = h_sync_s + CW'(tm.h_sync);
    assign h_last   = h_sync_e + CW'(tm.h_bp) - CW'(1);

    assign v_act    = CW'(tm.v_active);
    assign v_sync_s = v_act + CW'(tm.v_fp);
    assign v_sync_e = v_sync_s + CW'(tm.v_sync);
    assign v_last   = v_sync_e + CW'(tm.v_bp) - CW'(1);

    vga_axis_counter #(.CW(CW)) u_h_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_pix_stb),
        .i_last  (h_last),
        .o_count (h_count),
        .o_tc    (h_tc)
    );

    vga_axis_counter #(.CW(CW)) u_v_cnt (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_en    (i_pix_stb & h_tc),
        .i_last  (v_last),
        .o_count (v_count),
        .o_tc    (v_tc)
    );

    assign frame_wrap = i_pix_stb & h_tc & v_tc;

    // Both counters return to 0 on the same strobe that latches the new mode,
    // so the new mode's limits never see an out-of-range count.
    always_comb begin
        mode_d = mode_q;
        if (frame_wrap) begin
            mode_d = i_mode_sel;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q <= i_mode_sel;
        end else begin
            mode_q <= mode_d;
        end
    end

    assign hs_on = (h_count >= h_sync_s) && (h_count < h_sync_e);
    assign vs_on = (v_count >= v_sync_s) && (v_count < v_sync_e);

    assign o_mode        = mode_q;
    assign o_hs          = tm.h_pol ? hs_on : ~hs_on;
    assign o_vs          = tm.v_pol ? vs_on : ~vs_on;
    assign o_blanking    = (h_count >= h_act) || (v_count >= v_act);
    assign o_line_start  = (h_count == '0);
    assign o_frame_start = (h_count == '0) && (v_count == '0);
    assign o_animate     = h_tc && (v_count == v_act - CW'(1));
    assign o_x           = (h_count < h_act) ? h_count : h_act - CW'(1);
    assign o_y           = (v_count < v_act) ? v_count : v_act - CW'(1);

`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [15:0] frame_cnt_q;
    logic [15:0] frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_wrap) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign o_frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator. Instance 0 uses the real 640x480 / 800x600
// modes for line-level checks; instance 1 uses small modes with the same
// structure so whole frames and mode switches fit in a short run.
module tb_vga_timing_generator;
    import vga_timing_pkg::*;

    localparam int CW = 12;
    localparam timing_t S0 = '{h_active: 16'd16, h_fp: 16'd2, h_sync: 16'd3, h_bp: 16'd3,
                               v_active: 16'd8,  v_fp: 16'd2, v_sync: 16'd2, v_bp: 16'd3,
                               h_pol: 1'b0, v_pol: 1'b0};   // 24 x 15
    localparam timing_t S1 = '{h_active: 16'd20, h_fp: 16'd2, h_sync: 16'd4, h_bp: 16'd4,
                               v_active: 16'd10, v_fp: 16'd1, v_sync: 16'd2, v_bp: 16'd3,
                               h_pol: 1'b1, v_pol: 1'b1};   // 30 x 16

    typedef logic [6+2*CW:0] vec_t;  // {mode,hs,vs,blank,ls,fs,anim,x,y}

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] stb = '0, sel = '0, rst = '0;
    logic [1:0] o_mode, o_hs, o_vs, o_blank, o_ls, o_fs, o_anim;
    logic [1:0][CW-1:0] ox, oy;
`ifdef VGA_TIMING_FRAME_COUNT_EN
    logic [1:0][15:0] fcnt;
`endif

    vga_timing_generator u_dut (
        .i_clk(clk), .i_rst(rst[0]), .i_pix_stb(stb[0]), .i_mode_sel(sel[0]),
        .o_mode(o_mode[0]), .o_hs(o_hs[0]), .o_vs(o_vs[0]), .o_blanking(o_blank[0]),
        .o_line_start(o_ls[0]), .o_frame_start(o_fs[0]), .o_animate(o_anim[0]),
        .o_x(ox[0]), .o_y(oy[0])
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .o_frame_cnt(fcnt[0])
`endif
    );

    vga_timing_generator #(.MODE0(S0), .MODE1(S1), .CW(CW)) u_small (
        .i_clk(clk), .i_rst(rst[1]), .i_pix_stb(stb[1]), .i_mode_sel(sel[1]),
        .o_mode(o_mode[1]), .o_hs(o_hs[1]), .o_vs(o_vs[1]), .o_blanking(o_blank[1]),
        .o_line_start(o_ls[1]), .o_frame_start(o_fs[1]), .o_animate(o_anim[1]),
        .o_x(ox[1]), .o_y(oy[1])
`ifdef VGA_TIMING_FRAME_COUNT_EN
        , .o_frame_cnt(fcnt[1])
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    vec_t q0[$], q1[$];
    vec_t exp_v, got_v, snap;

    // reference model state per instance
    int mh[2], mv[2], mfc[2];
    logic [1:0] mm = '0;

    function automatic timing_t mode_of(input int k, input logic m);
        if (k == 0) return m ? TIMING_800X600_60 : TIMING_640X480_60;
        return m ? S1 : S0;
    endfunction

    function automatic vec_t model_out(input int k);
        timing_t t = mode_of(k, mm[k]);
        int ha = int'(t.h_active), va = int'(t.v_active);
        int hs0 = ha + int'(t.h_fp), vs0 = va + int'(t.v_fp);
        int hs1 = hs0 + int'(t.h_sync), vs1 = vs0 + int'(t.v_sync);
        int ht = hs1 + int'(t.h_bp);
        logic hs_act = (mh[k] >= hs0) && (mh[k] < hs1);
        logic vs_act = (mv[k] >= vs0) && (mv[k] < vs1);
        int x = (mh[k] < ha) ? mh[k] : ha - 1;
        int y = (mv[k] < va) ? mv[k] : va - 1;
        logic [CW-1:0] xs = x[CW-1:0];
        logic [CW-1:0] ys = y[CW-1:0];
        return {mm[k], (t.h_pol ? hs_act : !hs_act), (t.v_pol ? vs_act : !vs_act),
                (mh[k] >= ha) || (mv[k] >= va), mh[k] == 0, (mh[k] == 0) && (mv[k] == 0),
                (mh[k] == ht - 1) && (mv[k] == va - 1), xs, ys};
    endfunction

    function automatic vec_t obs(input int k);
        return {o_mode[k], o_hs[k], o_vs[k], o_blank[k], o_ls[k], o_fs[k], o_anim[k], ox[k], oy[k]};
    endfunction

    // Drive one cycle into instance k, advance the model, push the expectation.
    task automatic drive(input int k, input logic s, input logic se, input logic r);
        timing_t t;
        int ht, vt;
        @(negedge clk);
        stb[k] = s; sel[k] = se; rst[k] = r;
        stb[1-k] = 1'b0; rst[1-k] = 1'b0;
        t  = mode_of(k, mm[k]);
        ht = int'(t.h_active + t.h_fp + t.h_sync + t.h_bp);
        vt = int'(t.v_active + t.v_fp + t.v_sync + t.v_bp);
        if (r) begin
            mh[k] = 0; mv[k] = 0; mm[k] = se; mfc[k] = 0;
        end else if (s) begin
            if (mh[k] == ht - 1) begin
                mh[k] = 0;
                if (mv[k] == vt - 1) begin
                    mv[k] = 0; mm[k] = se; mfc[k] = (mfc[k] + 1) & 32'hFFFF;
                end else begin
                    mv[k] = mv[k] + 1;
                end
            end else begin
                mh[k] = mh[k] + 1;
            end
        end
        if (k == 0) q0.push_back(model_out(0)); else q1.push_back(model_out(1));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(0, 1'b1, 1'b0, 1'b1);
        exp_v = q0.pop_front(); got_v = obs(0); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL reset0_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (got_v !== {7'b0110110, 12'd0, 12'd0}) begin
            n_err++; $display("FAIL reset0_values got=%h exp=%h", got_v, {7'b0110110, 24'd0});
        end
        // reset with strobe low still applies, and takes mode from i_mode_sel
        drive(1, 1'b0, 1'b1, 1'b1);
        exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL reset1_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++;
        if (got_v !== {7'b1000110, 12'd0, 12'd0}) begin
            n_err++; $display("FAIL reset1_values got=%h exp=%h", got_v, {7'b1000110, 24'd0});
        end
    endtask

    task automatic test_line_mode0();
        int cnt = 0, mn = 99999, mx = -1, ls_n = 0, ls_at = -1;
        for (int n = 1; n <= 800; n++) begin
            drive(0, 1'b1, 1'b0, 1'b0);
            exp_v = q0.pop_front(); got_v = obs(0); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL line0_sb n=%0d got=%h exp=%h", n, got_v, exp_v); end
            if (!o_hs[0]) begin cnt++; if (n % 800 < mn) mn = n % 800; if (n % 800 > mx) mx = n % 800; end
            if (o_ls[0]) begin ls_n++; ls_at = n; end
            if (n == 639 || n == 640 || n == 799) begin
                n_cmp++;
                if (ox[0] !== 12'd639) begin n_err++; $display("FAIL line0_x h=%0d got=%0d exp=639", n, ox[0]); end
            end
        end
        n_cmp++; if (cnt != 96)  begin n_err++; $display("FAIL line0_hs_cnt got=%0d exp=96", cnt); end
        n_cmp++; if (mn != 656)  begin n_err++; $display("FAIL line0_hs_first got=%0d exp=656", mn); end
        n_cmp++; if (mx != 751)  begin n_err++; $display("FAIL line0_hs_last got=%0d exp=751", mx); end
        n_cmp++; if (ls_n != 1 || ls_at != 800) begin
            n_err++; $display("FAIL line0_ls got=%0d@%0d exp=1@800", ls_n, ls_at);
        end
        n_cmp++; if (oy[0] !== 12'd1) begin n_err++; $display("FAIL line0_y got=%0d exp=1", oy[0]); end
    endtask

    task automatic test_line_mode1();
        int cnt = 0, mn = 99999, mx = -1;
        drive(0, 1'b1, 1'b1, 1'b1);
        exp_v = q0.pop_front(); got_v = obs(0); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL line1_rst_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++; if (o_mode[0] !== 1'b1) begin n_err++; $display("FAIL line1_mode got=%b exp=1", o_mode[0]); end
        for (int n = 1; n <= 1056; n++) begin
            drive(0, 1'b1, 1'b1, 1'b0);
            exp_v = q0.pop_front(); got_v = obs(0); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL line1_sb n=%0d got=%h exp=%h", n, got_v, exp_v); end
            if (o_hs[0]) begin cnt++; if (n % 1056 < mn) mn = n % 1056; if (n % 1056 > mx) mx = n % 1056; end
        end
        n_cmp++; if (cnt != 128) begin n_err++; $display("FAIL line1_hs_cnt got=%0d exp=128", cnt); end
        n_cmp++; if (mn != 840)  begin n_err++; $display("FAIL line1_hs_first got=%0d exp=840", mn); end
        n_cmp++; if (mx != 967)  begin n_err++; $display("FAIL line1_hs_last got=%0d exp=967", mx); end
    endtask

    task automatic test_frame();
        int an_n = 0, an_at = -1, vs_n = 0, vmn = 999, vmx = -1, fs_n = 0, fs_at = -1;
        drive(1, 1'b1, 1'b0, 1'b1);
        exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL frame_rst_sb got=%h exp=%h", got_v, exp_v); end
        for (int n = 1; n <= 360; n++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL frame_sb n=%0d got=%h exp=%h", n, got_v, exp_v); end
            if (o_anim[1]) begin an_n++; an_at = n; end
            if (!o_vs[1]) begin
                vs_n++;
                if ((n / 24) % 15 < vmn) vmn = (n / 24) % 15;
                if ((n / 24) % 15 > vmx) vmx = (n / 24) % 15;
            end
            if (o_fs[1]) begin fs_n++; fs_at = n; end
        end
        n_cmp++; if (an_n != 1 || an_at != 191) begin
            n_err++; $display("FAIL frame_animate got=%0d@%0d exp=1@191", an_n, an_at);
        end
        n_cmp++; if (vs_n != 48) begin n_err++; $display("FAIL frame_vs_cnt got=%0d exp=48", vs_n); end
        n_cmp++; if (vmn != 10 || vmx != 11) begin
            n_err++; $display("FAIL frame_vs_rows got=%0d..%0d exp=10..11", vmn, vmx);
        end
        n_cmp++; if (fs_n != 1 || fs_at != 360) begin
            n_err++; $display("FAIL frame_start got=%0d@%0d exp=1@360", fs_n, fs_at);
        end
    endtask

    task automatic test_mode_switch();
        int early = 0, hs_n = 0, hmn = 999, hmx = -1, vmn = 999, vmx = -1, fs_n = 0, fs_at = -1;
        for (int n = 1; n <= 360; n++) begin
            drive(1, 1'b1, (n > 72), 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL switch_sb n=%0d got=%h exp=%h", n, got_v, exp_v); end
            if (n < 360 && o_mode[1]) early++;
        end
        n_cmp++; if (early != 0) begin n_err++; $display("FAIL switch_early got=%0d exp=0", early); end
        n_cmp++; if (o_mode[1] !== 1'b1) begin n_err++; $display("FAIL switch_mode got=%b exp=1", o_mode[1]); end
        for (int n = 1; n <= 480; n++) begin
            drive(1, 1'b1, 1'b1, 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL switch1_sb n=%0d got=%h exp=%h", n, got_v, exp_v); end
            if (o_hs[1]) begin hs_n++; if (n % 30 < hmn) hmn = n % 30; if (n % 30 > hmx) hmx = n % 30; end
            if (o_vs[1]) begin
                if ((n / 30) % 16 < vmn) vmn = (n / 30) % 16;
                if ((n / 30) % 16 > vmx) vmx = (n / 30) % 16;
            end
            if (o_fs[1]) begin fs_n++; fs_at = n; end
        end
        n_cmp++; if (hs_n != 64) begin n_err++; $display("FAIL switch1_hs_cnt got=%0d exp=64", hs_n); end
        n_cmp++; if (hmn != 22 || hmx != 25) begin
            n_err++; $display("FAIL switch1_hs_cols got=%0d..%0d exp=22..25", hmn, hmx);
        end
        n_cmp++; if (vmn != 11 || vmx != 12) begin
            n_err++; $display("FAIL switch1_vs_rows got=%0d..%0d exp=11..12", vmn, vmx);
        end
        n_cmp++; if (fs_n != 1 || fs_at != 480) begin
            n_err++; $display("FAIL switch1_frame got=%0d@%0d exp=1@480", fs_n, fs_at);
        end
    endtask

    task automatic test_freeze();
        for (int n = 1; n <= 10; n++) begin
            drive(1, 1'b1, 1'b1, 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL freeze_pre n=%0d got=%h exp=%h", n, got_v, exp_v); end
        end
        snap = obs(1);
        for (int i = 0; i < 50; i++) begin
            drive(1, 1'b0, i[0], 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL freeze_sb i=%0d got=%h exp=%h", i, got_v, exp_v); end
            n_cmp++;
            if (got_v !== snap) begin n_err++; $display("FAIL freeze_hold i=%0d got=%h exp=%h", i, got_v, snap); end
        end
        drive(1, 1'b1, 1'b1, 1'b0);
        exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL freeze_resume_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++; if (ox[1] !== 12'd11) begin n_err++; $display("FAIL freeze_resume_x got=%0d exp=11", ox[1]); end
    endtask

    task automatic test_reset_mid();
        // from (11,0) in the 30x16 mode, walk to (5,4)
        for (int n = 1; n <= 114; n++) begin
            drive(1, 1'b1, 1'b1, 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL rstmid_pre n=%0d got=%h exp=%h", n, got_v, exp_v); end
        end
        drive(1, 1'b1, 1'b0, 1'b1);
        exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL rstmid_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++; if (got_v !== {7'b0110110, 24'd0}) begin
            n_err++; $display("FAIL rstmid_values got=%h exp=%h", got_v, {7'b0110110, 24'd0});
        end
        // walk to the wrap position (23,14) of the 24x15 mode, reset there
        for (int n = 1; n <= 359; n++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
            if (got_v !== exp_v) begin n_err++; $display("FAIL rstwrap_pre n=%0d got=%h exp=%h", n, got_v, exp_v); end
        end
        drive(1, 1'b1, 1'b1, 1'b1);
        exp_v = q1.pop_front(); got_v = obs(1); n_cmp++;
        if (got_v !== exp_v) begin n_err++; $display("FAIL rstwrap_sb got=%h exp=%h", got_v, exp_v); end
        n_cmp++; if (got_v !== {7'b1000110, 24'd0}) begin
            n_err++; $display("FAIL rstwrap_values got=%h exp=%h", got_v, {7'b1000110, 24'd0});
        end
    endtask

`ifdef VGA_TIMING_FRAME_COUNT_EN
    task automatic test_frame_cnt();
        drive(1, 1'b0, 1'b0, 1'b1);
        void'(q1.pop_front());
        n_cmp++; if (fcnt[1] !== 16'd0) begin n_err++; $display("FAIL fcnt_reset got=%0d exp=0", fcnt[1]); end
        for (int n = 1; n <= 3 * 360; n++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            void'(q1.pop_front());
        end
        n_cmp++; if (fcnt[1] !== 16'(mfc[1]) || mfc[1] != 3) begin
            n_err++; $display("FAIL fcnt_three got=%0d exp=3", fcnt[1]);
        end
        @(negedge clk);
        force u_small.frame_cnt_q = 16'hFFFF;
        #1;
        release u_small.frame_cnt_q;
        mfc[1] = 32'hFFFF;
        for (int n = 1; n <= 360; n++) begin
            drive(1, 1'b1, 1'b0, 1'b0);
            void'(q1.pop_front());
        end
        n_cmp++; if (fcnt[1] !== 16'd0 || mfc[1] != 0) begin
            n_err++; $display("FAIL fcnt_wrap got=%0d exp=0", fcnt[1]);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_line_mode0();
        test_line_mode1();
        test_frame();
        test_mode_switch();
        test_freeze();
        test_reset_mid();
`ifdef VGA_TIMING_FRAME_COUNT_EN
        test_frame_cnt();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vga_timing_generator.md
VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 SHALL have parameter MODE0, type timing_t, default TIMING_640X480_60 (h/v active, front porch, sync, back porch, sync polarity).
REQ-002 SHALL have parameter MODE1, type timing_t, default TIMING_800X600_60; the alternate mode.
REQ-003 SHALL have parameter CW, default 12; width of counters and of o_x/o_y.
REQ-004 SHALL have port i_clk, input, 1, the single clock; all logic runs on its rising edge.
REQ-005 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-006 SHALL have port i_pix_stb, input, 1, pixel strobe; state advances only on cycles where it is high.
REQ-007 SHALL have port i_mode_sel, input, 1, requested mode (0 selects MODE0, 1 selects MODE1).
REQ-008 SHALL have port o_mode, output, 1, mode currently being generated.
REQ-009 SHALL have ports o_hs and o_vs, outputs, 1 each, sync pulses at the polarity given by the active mode.
REQ-010 SHALL have port o_blanking, output, 1, high outside the active region.
REQ-011 SHALL have port o_line_start, output, 1, high while h_count==0.
REQ-012 SHALL have port o_frame_start, output, 1, high while h_count==0 and v_count==0.
REQ-013 SHALL have port o_animate, output, 1, high while h_count==H_TOTAL-1 and v_count==V_ACTIVE-1.
REQ-014 SHALL have ports o_x and o_y, outputs, CW each, current active pixel coordinates.

Function
REQ-015 SHALL use H_TOTAL = h_active+h_fp+h_sync+h_bp and V_TOTAL likewise, taken from the active mode; line order is active, front porch, sync, back porch.
REQ-016 SHALL keep h_count in 0..H_TOTAL-1, incrementing on each strobe and wrapping to 0 after H_TOTAL-1, with no extra count.
REQ-017 SHALL increment v_count by one on the strobe that wraps h_count, and wrap v_count from V_TOTAL-1 to 0.
REQ-018 SHALL make sync active for h_count in [h_active+h_fp, h_active+h_fp+h_sync), with the same rule for v_count.
REQ-019 SHALL drive o_x=h_count when h_count<h_active, otherwise h_active-1; o_y likewise against v_active.
REQ-020 SHALL make all outputs a pure decode of the registered counters and mode, giving zero strobe latency.
REQ-021 SHALL sample i_mode_sel only on the strobe where h_count==H_TOTAL-1 and v_count==V_TOTAL-1, and take the new mode from that wrap onward; mid-frame changes are ignored.
REQ-022 SHALL hold all state and outputs unchanged while i_pix_stb is low.
REQ-023 SHALL give every CW-bit comparison and add exactly CW bits, with no truncation for totals up to 2^CW-1.

Reset
REQ-024 SHALL, on i_rst high at a clock edge, set h_count=0, v_count=0 and mode=i_mode_sel, regardless of i_pix_stb.
REQ-025 SHALL hold the following values after reset: o_hs/o_vs inactive, o_blanking=0, o_line_start=1, o_frame_start=1, o_animate=0, o_x=0, o_y=0.
REQ-026 SHALL give i_rst priority over the strobe, including mid-frame and at the wrap cycle.

Configuration
REQ-027 SHALL, when VGA_TIMING_FRAME_COUNT_EN is defined, add output o_frame_cnt[15:0]: reset to 0, incremented on every frame wrap, wrapping 0xFFFF->0.
REQ-028 SHALL, when VGA_TIMING_FRAME_COUNT_EN is undefined, omit o_frame_cnt and its register, leaving all other behaviour identical.

Structure
REQ-029 SHALL place timing_t, TIMING_640X480_60 (640/16/96/48, 480/10/2/33, both syncs active-low) and TIMING_800X600_60 (800/40/128/88, 600/1/4/23, both active-high) in package vga_timing_pkg.
REQ-030 SHALL use one sub-module, vga_axis_counter (wrapping counter with enable and terminal-count output), instantiated once for horizontal and once for vertical.

Verification
REQ-031 SHALL cover: reset, mode 0, 800 strobes -> o_hs low at h 656..751 only; o_x 0..639 then held at 639; o_line_start high at h=0 only.
REQ-032 SHALL cover: mode 0, full frame -> 420000 strobes; o_vs low at v 490..491; o_animate once at (799,479); o_frame_start again after exactly 420000 strobes.
REQ-033 SHALL cover: i_mode_sel 0->1 at v=100 -> o_mode stays 0 until wrap (799,524); next frame is 1056x628 with o_hs high at h 840..967.
REQ-034 SHALL cover: i_pix_stb low for 50 cycles mid-line -> all outputs frozen, then resume from the same h_count.
REQ-035 SHALL cover: i_rst pulsed at (300,200) with strobe high -> next cycle h=v=0, o_frame_start=1, mode=i_mode_sel.
REQ-036 SHALL cover, with VGA_TIMING_FRAME_COUNT_EN: 3 frames -> o_frame_cnt=3; counter forced to 0xFFFF then one frame -> 0.
